// File: rtl/det_weight_loader.sv
// Weight-write sequencer for the detection network: maps a flat word stream
// onto (layer, neuron, weight) addresses in fixed load order.
module det_weight_loader #(
  parameter int WORD_W      = 64,
  parameter int NUM_LAYERS  = 7,
  parameter int TOTAL_WORDS = 1257
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              write_weight,
  output logic [2:0]        layer_sel,
  output logic [3:0]        neuron_sel,
  output logic [6:0]        weight_sel,
  output logic [WORD_W-1:0] weight_bus,
  output logic              busy,
  output logic              done,
  output logic [10:0]       word_count
);

  typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;

  localparam logic [10:0] LAST_CNT = 11'(TOTAL_WORDS - 1);
  localparam logic [2:0]  N_LAYER  = 3'(NUM_LAYERS);

  state_t state, state_nx;

  logic [2:0] layer;
  logic [3:0] neuron;
  logic [6:0] wsel;
  logic       hs;
  logic       wrap_w;
  logic       wrap_n;

  function automatic logic [3:0] lsize(input logic [2:0] l);
    logic [3:0] r;
    r = '0;
    if (l < N_LAYER) begin
      case (l)
        3'd0:    r = 4'd4;
        3'd1:    r = 4'd15;
        3'd2:    r = 4'd5;
        default: r = 4'd1;
      endcase
      if (l == 3'd1) r = 4'd15;
    end
    return r;
  endfunction

  function automatic logic [6:0] isize(input logic [2:0] l);
    logic [6:0] r;
    r = '0;
    if (l < N_LAYER) begin
      case (l)
        3'd0:    r = 7'd100;
        3'd1:    r = 7'd25;
        3'd2:    r = 7'd80;
        3'd3:    r = 7'd4;
        3'd4:    r = 7'd16;
        3'd5:    r = 7'd5;
        default: r = 7'd3;
      endcase
    end
    return r;
  endfunction

  // layer 1 has 16 neurons; lsize holds the last neuron index there
  logic [3:0] last_n;
  always_comb begin
    last_n = lsize(layer);
    if (layer != 3'd1) last_n = last_n - 4'd1;
  end

  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign hs       = in_valid & in_ready;
  assign wrap_w   = (wsel == isize(layer));
  assign wrap_n   = wrap_w && (neuron == last_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: if (hs && word_count == LAST_CNT) state_nx = FIN;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_weight <= 1'b0;
      done         <= 1'b0;
      layer_sel    <= '0;
      neuron_sel   <= '0;
      weight_sel   <= '0;
      weight_bus   <= '0;
      word_count   <= '0;
      layer        <= '0;
      neuron       <= '0;
      wsel         <= '0;
    end else begin
      write_weight <= hs;
      done         <= (state == FIN);
      if (state == IDLE && start) begin
        layer      <= '0;
        neuron     <= '0;
        wsel       <= '0;
        word_count <= '0;
      end
      if (hs) begin
        weight_bus <= in_data;
        layer_sel  <= layer;
        neuron_sel <= neuron;
        weight_sel <= wsel;
        word_count <= word_count + 11'd1;
        if (!wrap_w) begin
          wsel <= wsel + 7'd1;
        end else begin
          wsel <= '0;
          if (wrap_n) begin
            neuron <= '0;
            layer  <= layer + 3'd1;
          end else begin
            neuron <= neuron + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_det_weight_loader.sv
// Directed bench for det_weight_loader: full loads, stalls, restart
// attempts, mid-load reset and an address scoreboard.
module tb_det_weight_loader;

  localparam int N = 1257;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_ready;
  logic        write_weight;
  logic [2:0]  layer_sel;
  logic [3:0]  neuron_sel;
  logic [6:0]  weight_sel;
  logic [63:0] weight_bus;
  logic        busy;
  logic        done;
  logic [10:0] word_count;

  det_weight_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .write_weight(write_weight), .layer_sel(layer_sel),
    .neuron_sel(neuron_sel), .weight_sel(weight_sel),
    .weight_bus(weight_bus), .busy(busy), .done(done),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  bit stab = 1'b0;
  logic [13:0] prev_sel = '0;
  logic [13:0] eaddr [N];
  logic [13:0] qa [$];
  logic [63:0] qb [$];
  int ls [7] = '{4, 16, 5, 1, 1, 1, 1};
  int is [7] = '{100, 25, 80, 4, 16, 5, 3};

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [13:0] cur;
    @(posedge clk);
    #1;
    cur = {layer_sel, neuron_sel, weight_sel};
    if (write_weight) begin
      qa.push_back(cur);
      qb.push_back(weight_bus);
    end
    if (done) done_cnt++;
    if (stab && in_ready && !write_weight) chk("stall_hold", cur, prev_sel);
    prev_sel = cur;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input bit stall, input int mid_start, input int stop_at);
    int idx = 0;
    int guard = 0;
    bit v, rdy;
    while (idx < stop_at && guard < 20000) begin
      rdy = in_ready;
      v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      in_data = 64'(idx);
      start = (idx == mid_start);
      tick();
      if (v && rdy) idx++;
      guard++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk("feed_budget", 64'(guard < 20000), 64'd1);
  endtask

  task automatic finish_load(input string tag);
    chk({tag, "_last_wr"}, 64'(write_weight), 64'd1);
    chk({tag, "_rdy_drop"}, 64'(in_ready), 64'd0);
    chk({tag, "_done_early"}, 64'(done), 64'd0);
    tick();
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy_off"}, 64'(busy), 64'd0);
    chk({tag, "_wcount"}, 64'(word_count), 64'd1257);
    repeat (3) tick();
    chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_nwrites"}, 64'(qa.size()), 64'(N));
    for (int i = 0; i < N && i < qa.size(); i++) begin
      chk({tag, "_addr"}, 64'(qa[i]), 64'(eaddr[i]));
      chk({tag, "_data"}, qb[i], 64'(i));
    end
  endtask

  task automatic scoreboard();
    bit seen [7][16][101];
    int wmax [7];
    int ncnt [7];
    int dup = 0;
    int l, n, w;
    foreach (qa[i]) begin
      l = int'(qa[i][13:11]);
      n = int'(qa[i][10:7]);
      w = int'(qa[i][6:0]);
      if (l < 7 && w <= 100) begin
        if (seen[l][n][w]) dup++;
        seen[l][n][w] = 1'b1;
        if (w > wmax[l]) wmax[l] = w;
      end else begin
        dup++;
      end
    end
    for (int a = 0; a < 7; a++)
      for (int b = 0; b < 16; b++)
        if (seen[a][b][0]) ncnt[a]++;
    chk("sb_dup", 64'(dup), 64'd0);
    for (int a = 0; a < 7; a++) begin
      chk("sb_neurons", 64'(ncnt[a]), 64'(ls[a]));
      chk("sb_wmax", 64'(wmax[a]), 64'(is[a]));
    end
  endtask

  initial begin
    int k = 0;
    for (int l = 0; l < 7; l++)
      for (int n = 0; n < ls[l]; n++)
        for (int w = 0; w <= is[l]; w++) begin
          eaddr[k] = {3'(l), 4'(n), 7'(w)};
          k++;
        end

    #12;
    chk("rst_outs", {in_ready, write_weight, busy, done, layer_sel,
        neuron_sel, weight_sel, word_count}, 64'd0);
    chk("rst_bus", weight_bus, 64'd0);
    rst_n = 1'b1;
    tick();

    // idle: valid without start must not be consumed
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_rdy", 64'(in_ready), 64'd0);
    end
    chk("idle_nowr", 64'(qa.size()), 64'd0);
    in_valid = 1'b0;

    // back-to-back full load
    pulse_start();
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_rdy", 64'(in_ready), 64'd1);
    done_cnt = 0;
    feed(1'b0, -1, N);
    finish_load("b2b");
    check_seq("b2b");
    chk("w101", 64'(qa[101]), 64'({3'd0, 4'd1, 7'd0}));
    chk("w404", 64'(qa[404]), 64'({3'd1, 4'd0, 7'd0}));
    chk("w1256", 64'(qa[1256]), 64'({3'd6, 4'd0, 7'd3}));
    scoreboard();

    // stalled load with start pulsed mid-load
    qa.delete(); qb.delete();
    done_cnt = 0;
    stab = 1'b1;
    pulse_start();
    feed(1'b1, 300, N);
    finish_load("stall");
    stab = 1'b0;
    check_seq("stall");

    // reset mid-load, then a full reload
    qa.delete(); qb.delete();
    done_cnt = 0;
    pulse_start();
    feed(1'b0, -1, 700);
    rst_n = 1'b0;
    #1;
    chk("arst_outs", {in_ready, write_weight, busy, done, layer_sel,
        neuron_sel, weight_sel, word_count}, 64'd0);
    chk("arst_bus", weight_bus, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("arst_nodone", 64'(done_cnt), 64'd0);
    chk("arst_idle", 64'(busy), 64'd0);
    qa.delete(); qb.delete();
    pulse_start();
    feed(1'b0, -1, N);
    finish_load("reload");
    check_seq("reload");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
